imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// Writer side of the instruction-memory interface: fetch only reads imem, this block fills it.
// Takes a byte stream (valid/ready) holding header + program + checksum and packs it into 32-bit words.
// Writes each word to memory through addr/data/write_en while holding the core in reset.
// Releases the core when the image is loaded and the checksum matches.
// PARAMETERS
// AWIDTH          32             address width of the imem write port
// DWIDTH          32             data width; fixed at 32 (4 bytes per word)
// IMEM_BASE_ADDR  32'h0100_0000  address of word 0 of the image
// MAX_WORDS       1024           largest legal word count; a larger header is an error
// PORTS
// clk          in   1       clock; all logic on posedge
// rst          in   1       synchronous, active-high reset
// start_i      in   1       pulse; starts a load (honoured in IDLE, DONE, ERR only)
// byte_i       in   8       stream byte
// byte_valid_i in   1       byte_i is valid
// byte_ready_o out  1       loader accepts byte this cycle
// addr_o       out  AWIDTH  imem write address
// data_o       out  DWIDTH  imem write data
// write_en_o   out  1       imem write strike (read_en stays with fetch)
// busy_o       out  1       load in progress (HDR/DATA/WRITE/CSUM)
// done_o       out  1       image loaded, checksum good (level)
// err_o        out  1       bad count or checksum (level)
// core_rst_o   out  1       reset to fetch/decode; 1 in every state except DONE
// BEHAVIOUR
// - Reset: state=IDLE. byte_ready_o=0, write_en_o=0, addr_o=0, data_o=0, busy_o=0, done_o=0,
//   err_o=0, core_rst_o=1. Word index, byte counter and checksum cleared.
// - Byte transfer = byte_valid_i & byte_ready_o in the same cycle.
// - byte_ready_o=1 only in HDR, DATA, CSUM. Stalls on byte_valid_i=0 keep all state.
// - States:
//   IDLE->HDR on start_i.
//   HDR: 4 bytes, little-endian -> count. On the 4th byte: count>MAX_WORDS->ERR; count==0->CSUM; else->DATA.
//   DATA: 4 bytes, little-endian (1st byte = data[7:0]). On the 4th byte ->WRITE.
//   WRITE: exactly 1 cycle. write_en_o=1, addr_o=IMEM_BASE_ADDR+(idx<<2), data_o=word, idx++.
//     Then idx==count->CSUM, else ->DATA. Total 5 cycles minimum per word.
//   CSUM: 1 byte. (sum8 of all header+data bytes + csum byte) mod 256 == 0 -> DONE, else ERR.
//   DONE: done_o=1, core_rst_o=0. ERR: err_o=1, core_rst_o=1.
//   From DONE or ERR, start_i -> HDR and clears done_o/err_o, idx and checksum.
// - write_en_o is 1 only in WRITE. addr_o/data_o hold their last value otherwise.
// - busy_o=1 in HDR, DATA, WRITE, CSUM.
// - Address arithmetic is AWIDTH-bit. idx is wide enough for MAX_WORDS; no wrap when count<=MAX_WORDS.
// - start_i while busy_o=1 is ignored.
// - rst mid-load: returns to IDLE next edge with reset outputs. The partial word is dropped and not written.
//   Words already written stay in memory.
// - core_rst_o is combinational from state: it goes low in the first DONE cycle.
// TESTING
// T1 start; bytes 01 00 00 00 | 13 00 00 00 | EC -> one write addr=0x0100_0000 data=0x0000_0013;
//    done_o=1, core_rst_o=0.
// T2 count=3, words 0x00500093, 0x00A00113, 0x002081B3, correct csum -> 3 writes at 0x0100_0000/04/08
//    in order; done_o=1.
// T3 as T1 but csum byte ED -> write still occurs; err_o=1, done_o=0, core_rst_o=1.
// T4 header count=1025 (01 04 00 00) -> ERR after 4th byte; no write_en_o; byte_ready_o=0.
// T5 byte_valid_i toggles every other cycle during T2 -> identical writes/addresses; busy_o held throughout.
// T6 rst after 2 data bytes of word 2 in T2 -> IDLE, only word 0 written, all outputs at reset values;
//    new start + full T1 -> done_o=1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: unpacks a header + program + checksum byte stream into 32-bit imem writes.
// The core is held in reset until a complete image with a matching checksum has been written.
module imem_loader #(
    parameter int                AWIDTH         = 32,
    parameter int                DWIDTH         = 32,
    parameter logic [AWIDTH-1:0] IMEM_BASE_ADDR = 32'h0100_0000,
    parameter int                MAX_WORDS      = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [AWIDTH-1:0] addr_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              write_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              core_rst_o
);

    localparam int IDXW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [23:0]       r_shift;
    logic [1:0]        r_bcnt;
    logic [7:0]        r_sum;
    logic [IDXW-1:0]   r_idx;
    logic [IDXW-1:0]   r_count;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_data;
    logic              r_we;

    logic              w_xfer;
    logic              w_last_byte;
    logic [31:0]       w_word;
    logic [7:0]        w_sum_next;
    logic [IDXW-1:0]   w_idx_next;

    // Little-endian assembly: the newest byte lands on top, so byte 0 ends up in [7:0].
    assign w_word      = {byte_i, r_shift};
    assign w_xfer      = byte_valid_i & byte_ready_o;
    assign w_last_byte = (r_bcnt == 2'd3);
    assign w_sum_next  = r_sum + byte_i;
    assign w_idx_next  = r_idx + 1'b1;

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        r_state <= S_HDR;
                        r_bcnt  <= '0;
                        r_sum   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_shift <= w_word[31:8];
                        r_sum   <= w_sum_next;
                        r_bcnt  <= r_bcnt + 2'd1;
                        if (w_last_byte) begin
                            r_count <= w_word[IDXW-1:0];
                            if (w_word > 32'(MAX_WORDS)) begin
                                r_state <= S_ERR;
                            end else if (w_word == 32'd0) begin
                                r_state <= S_CSUM;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_shift <= w_word[31:8];
                        r_sum   <= w_sum_next;
                        r_bcnt  <= r_bcnt + 2'd1;
                        if (w_last_byte) begin
                            // Address and data are staged here so they are valid for the whole WRITE cycle.
                            r_addr  <= IMEM_BASE_ADDR + (AWIDTH'(r_idx) << 2);
                            r_data  <= DWIDTH'(w_word);
                            r_we    <= 1'b1;
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_we    <= 1'b0;
                    r_idx   <= w_idx_next;
                    r_state <= (w_idx_next == r_count) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_state <= (w_sum_next == 8'd0) ? S_DONE : S_ERR;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign byte_ready_o = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign busy_o       = byte_ready_o || (r_state == S_WRITE);
    assign done_o       = (r_state == S_DONE);
    assign err_o        = (r_state == S_ERR);
    assign core_rst_o   = (r_state != S_DONE);
    assign addr_o       = r_addr;
    assign data_o       = r_data;
    assign write_en_o   = r_we;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: good images, bad checksum, oversize header,
// stalled stream and mid-load reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic        write_en_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        core_rst_o;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_drop;

    logic [31:0] wa [0:63];
    logic [31:0] wd [0:63];
    int          wr_n = 0;
    int          base;

    logic [7:0]  img [$];

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .addr_o       (addr_o),
        .data_o       (data_o),
        .write_en_o   (write_en_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .core_rst_o   (core_rst_o)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (write_en_o && wr_n < 64) begin
            wa[wr_n] = addr_o;
            wd[wr_n] = data_o;
            wr_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        check({tag, "_we"},    32'(write_en_o),   32'd0);
        check({tag, "_addr"},  addr_o,            32'd0);
        check({tag, "_data"},  data_o,            32'd0);
        check({tag, "_busy"},  32'(busy_o),       32'd0);
        check({tag, "_done"},  32'(done_o),       32'd0);
        check({tag, "_err"},   32'(err_o),        32'd0);
        check({tag, "_crst"},  32'(core_rst_o),   32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        if (gap) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
            if (!busy_o) busy_drop++;
        end
        @(negedge clk);
        byte_i       = b;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && n < 50) begin
            if (!busy_o) busy_drop++;
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 byte_valid_i = 1'b0;
    endtask

    task automatic send_img(input int nbytes, input bit gap);
        for (int i = 0; i < nbytes; i++) send_byte(img[i], gap);
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        busy_drop    = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // T1: single word, good checksum (01+13+EC = 0x100)
        base = wr_n;
        img = {8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEC};
        pulse_start();
        check("t1_busy_after_start", 32'(busy_o), 32'd1);
        send_img(9, 1'b0);
        check("t1_done", 32'(done_o), 32'd1);
        check("t1_err", 32'(err_o), 32'd0);
        check("t1_crst", 32'(core_rst_o), 32'd0);
        check("t1_busy", 32'(busy_o), 32'd0);
        check("t1_nwr", 32'(wr_n - base), 32'd1);
        check("t1_addr", wa[base], 32'h0100_0000);
        check("t1_data", wd[base], 32'h0000_0013);

        // T2: three words, checksum 0x12 (byte sum 0x2EE)
        base = wr_n;
        img = {8'h03, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'hA0, 8'h00,
               8'hB3, 8'h81, 8'h20, 8'h00,
               8'h12};
        pulse_start();
        check("t2_done_cleared", 32'(done_o), 32'd0);
        check("t2_crst_on_restart", 32'(core_rst_o), 32'd1);
        send_img(17, 1'b0);
        check("t2_done", 32'(done_o), 32'd1);
        check("t2_nwr", 32'(wr_n - base), 32'd3);
        check("t2_addr0", wa[base],     32'h0100_0000);
        check("t2_data0", wd[base],     32'h0050_0093);
        check("t2_addr1", wa[base + 1], 32'h0100_0004);
        check("t2_data1", wd[base + 1], 32'h00A0_0113);
        check("t2_addr2", wa[base + 2], 32'h0100_0008);
        check("t2_data2", wd[base + 2], 32'h0020_81B3);

        // T3: as T1 with a bad checksum byte
        base = wr_n;
        img = {8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hED};
        pulse_start();
        send_img(9, 1'b0);
        check("t3_err", 32'(err_o), 32'd1);
        check("t3_done", 32'(done_o), 32'd0);
        check("t3_crst", 32'(core_rst_o), 32'd1);
        check("t3_nwr", 32'(wr_n - base), 32'd1);
        check("t3_data", wd[base], 32'h0000_0013);

        // T4: count 1025 exceeds the limit
        base = wr_n;
        img = {8'h01, 8'h04, 8'h00, 8'h00};
        pulse_start();
        check("t4_err_cleared", 32'(err_o), 32'd0);
        send_img(4, 1'b0);
        check("t4_err", 32'(err_o), 32'd1);
        check("t4_ready", 32'(byte_ready_o), 32'd0);
        check("t4_busy", 32'(busy_o), 32'd0);
        check("t4_nwr", 32'(wr_n - base), 32'd0);

        // T5: T2 image with a stall cycle before every byte
        base = wr_n;
        busy_drop = 0;
        img = {8'h03, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'hA0, 8'h00,
               8'hB3, 8'h81, 8'h20, 8'h00,
               8'h12};
        pulse_start();
        send_img(17, 1'b1);
        check("t5_busy_held", 32'(busy_drop), 32'd0);
        check("t5_done", 32'(done_o), 32'd1);
        check("t5_nwr", 32'(wr_n - base), 32'd3);
        check("t5_addr1", wa[base + 1], 32'h0100_0004);
        check("t5_data1", wd[base + 1], 32'h00A0_0113);
        check("t5_addr2", wa[base + 2], 32'h0100_0008);
        check("t5_data2", wd[base + 2], 32'h0020_81B3);

        // T6: reset after two bytes of the second word, then a clean T1 load
        base = wr_n;
        pulse_start();
        send_img(10, 1'b0);
        check("t6_busy_mid", 32'(busy_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        repeat (3) @(negedge clk);
        check("t6_nwr", 32'(wr_n - base), 32'd1);
        check("t6_data0", wd[base], 32'h0050_0093);
        rst = 1'b0;
        base = wr_n;
        img = {8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEC};
        pulse_start();
        send_img(9, 1'b0);
        check("t6_done", 32'(done_o), 32'd1);
        check("t6_crst", 32'(core_rst_o), 32'd0);
        check("t6_nwr2", 32'(wr_n - base), 32'd1);
        check("t6_addr", wa[base], 32'h0100_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
